// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the multicycle fetch/PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_EX
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
    localparam int unsigned PC_STEP_DEFAULT    = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect target selection: word-aligns the branch/jump target, or with
// PC_ALIGN_CHECK_EN flags a misaligned target and substitutes the exception vector.
module pc_redirect_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned          W          = 32,
    parameter logic [W-1:0]         EXC_VECTOR = W'(EXC_VECTOR_DEFAULT)
) (
    input  logic [W-1:0] target,
`ifdef PC_ALIGN_CHECK_EN
    output logic         misaligned,
`endif
    output logic [W-1:0] target_sel
);

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        misaligned = |target[1:0];
        target_sel = misaligned ? EXC_VECTOR : target;
    end
`else
    // Low two bits are simply cleared: {target[W-1:2], 2'b00}.
    always_comb begin
        target_sel = target & ~{{(W-2){1'b0}}, 2'b11};
    end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/PC controller: owns the PC, sequences the external PC+4 adder.
// Optional misaligned-redirect exception is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned                WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0]     RESET_PC    = WORD_LENGTH'(RESET_PC_DEFAULT),
    parameter logic [WORD_LENGTH-1:0]     PC_STEP     = WORD_LENGTH'(PC_STEP_DEFAULT),
    parameter logic [WORD_LENGTH-1:0]     EXC_VECTOR  = WORD_LENGTH'(EXC_VECTOR_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt,
    output logic                   imem_req,
    input  logic                   imem_ready,
    input  logic [WORD_LENGTH-1:0] imem_rdata,
    output logic [WORD_LENGTH-1:0] adder_a,
    output logic [WORD_LENGTH-1:0] adder_b,
    input  logic [WORD_LENGTH-1:0] adder_y,
    output logic [WORD_LENGTH-1:0] pc,
    output logic [WORD_LENGTH-1:0] pc_plus4,
    output logic [WORD_LENGTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   done_i,
    input  logic                   redirect,
    input  logic [WORD_LENGTH-1:0] redirect_target,
    output logic                   misalign_exc,
    output logic [WORD_LENGTH-1:0] epc
);

    state_t                 state, state_next;
    logic [WORD_LENGTH-1:0] target_sel;
    logic                   pc_update;
`ifdef PC_ALIGN_CHECK_EN
    logic                   misaligned;
`endif

    pc_redirect_sel #(
        .W          (WORD_LENGTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_sel (
        .target     (redirect_target),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .target_sel (target_sel)
    );

    assign adder_a   = pc;
    assign adder_b   = PC_STEP;
    assign pc_update = (state == WAIT_EX) && done_i;

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_next = ISSUE;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                state_next  = WAIT_EX;
            end
            WAIT_EX: if (done_i) state_next = halt ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            pc_plus4 <= '0;
            instr    <= '0;
        end else begin
            state <= state_next;
            if ((state == FETCH) && imem_ready) begin
                instr    <= imem_rdata;
                pc_plus4 <= adder_y;
            end
            if (pc_update) begin
                pc <= redirect ? target_sel : pc_plus4;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Only redirects are checked; the sequential PC+4 path is always aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_exc <= 1'b0;
            epc          <= '0;
        end else begin
            misalign_exc <= 1'b0;
            if (pc_update && redirect && misaligned) begin
                misalign_exc <= 1'b1;
                epc          <= pc;
            end
        end
    end
`else
    assign misalign_exc = 1'b0;
    assign epc          = '0;
`endif

endmodule
